bsg_manycore_mem_responder: RTL and testbench
=============================================

Name: bsg_manycore_mem_responder

Overview:
- Sits directly downstream of the manycore endpoint's incoming-request FIFO (fifo_data_o / fifo_v_o / fifo_yumi_i).
- Decodes each request packet and drives a 1-cycle-latency synchronous local SRAM.
- Builds the return packet and feeds the endpoint's returning_data_i / returning_v_i / returning_ready_o interface.
- Returns a credit for every store and read data for every load, in request order.

Parameters:
- x_cord_width_p, "inv": X coordinate width.
- y_cord_width_p, "inv": Y coordinate width.
- data_width_p, 32: payload and memory word width.
- addr_width_p, 32: packet word-address width.
- load_id_width_p, 5: load ID width.
- mem_addr_width_p, 10: SRAM word-address width; SRAM holds 2^mem_addr_width_p words.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset (0 = reset).
- in_packet_i  in  packet width  request packet from the endpoint FIFO.
- in_v_i  in  1  request valid.
- in_yumi_o  out  1  request consumed this cycle.
- mem_v_o  out  1  SRAM access this cycle.
- mem_w_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  mem_addr_width_p  SRAM word address.
- mem_data_o  out  data_width_p  write data.
- mem_mask_o  out  data_width_p/8  byte write mask.
- mem_data_i  in  data_width_p  read data, valid the cycle after a read.
- return_packet_o  out  return packet width  response packet.
- return_v_o  out  1  response valid.
- return_ready_i  in  1  endpoint accepts the response.
- error_o  out  1  out-of-range pulse (see Optional Feature).

Behaviour:
- Reset (reset_i=0 at posedge): state=IDLE; in_yumi_o=0, mem_v_o=0, return_v_o=0, error_o=0. The response register is cleared to 0.
- Packet decode: op is load or store. Also extracts addr, payload, mask, src_x, src_y, load_id. mem_addr_o = addr[mem_addr_width_p-1:0].
- FSM states: IDLE, RESP, HOLD.
- IDLE:
  - If in_v_i=1: assert in_yumi_o and mem_v_o combinationally in the same cycle, with mem_w_o = (op==store). Capture the return header (type, load_id, src_x, src_y) and go to RESP.
- RESP:
  - return_v_o=1. Data field = mem_data_i for a load (the SRAM output is live only this cycle), 0 for a store. Return type = store credit or load data. Dest = captured src_x/src_y.
  - return_ready_i=1 and in_v_i=1: back-to-back. Accept the next request this cycle and stay in RESP. Throughput is 1 request/cycle.
  - return_ready_i=1 and in_v_i=0: go to IDLE.
  - return_ready_i=0: latch the response data (including mem_data_i) into the hold register and go to HOLD. No new request is accepted.
- HOLD:
  - return_v_o=1 with the held packet; mem_v_o=0, in_yumi_o=0.
  - return_ready_i=1: go to IDLE. Next-request acceptance is deferred one cycle, so no SRAM read is outstanding while a hold is pending.
- Invariants:
  - At most one response is outstanding.
  - Responses are returned in request order.
  - in_yumi_o is never asserted while in HOLD, or while in RESP with return_ready_i=0.
  - return_packet_o is stable while return_v_o=1 and return_ready_i=0.
- Reset mid-operation: any pending response is discarded, with no partial handshake. The upstream FIFO retains unconsumed packets.

Optional Feature:
- Macro: BSG_MANYCORE_MEM_RESPONDER_ADDR_CHECK_EN.
- Defined:
  - A request with addr >= 2^mem_addr_width_p is still consumed, but mem_v_o=0.
  - Load returns data 0; store returns a normal credit.
  - error_o pulses 1 for exactly the acceptance cycle.
- Undefined: no check; upper address bits are truncated; error_o tied to 0.

Decomposition:
- Shared package bsg_manycore_mem_responder_pkg holds:
  - the state enum (IDLE/RESP/HOLD);
  - the return-type constants (store credit, load data);
  - the op decode constants.
- Packet structs come from the existing manycore packet declaration macros.
- One sub-module, bsg_manycore_return_pkt_builder: combinational; assembles the return packet from the header plus data.

Test Plan:
- Store addr=0x10, payload=0xDEADBEEF, mask=4'hF, src(2,3), return_ready_i held 1 → SRAM write the same cycle; next cycle one store credit to (2,3); a later load of 0x10 returns 0xDEADBEEF.
- 4 back-to-back loads of addrs 0..3 preloaded with 0xA0..0xA3, return_ready_i=1 → one request per cycle; responses 0xA0..0xA3 in order with matching load_ids 0..3.
- Load addr 5 (=0x55), return_ready_i=0 for 3 cycles → return_packet_o stable holding 0x55; in_yumi_o=0 throughout; accepted on the 4th cycle.
- Store with mask=4'b0010 of 0x0000AB00 over 0x11223344 → readback 0x1122AB44.
- reset_i=0 asserted while in HOLD → next cycle return_v_o=0, state IDLE; the FIFO-retained request is serviced after release.
- With ADDR_CHECK_EN, load addr=2^mem_addr_width_p → mem_v_o=0, error_o=1 for 1 cycle, return data 0.

Source files
------------

// File: rtl/bsg_manycore_mem_responder_pkg.sv
// Shared types for the manycore memory responder: FSM states,
// request op codes, return packet types and packet width helpers.
package bsg_manycore_mem_responder_pkg;

    // Responder FSM: idle, presenting a live response, holding a stalled one.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Request op field encoding.
    localparam int op_width_gp = 2;

    typedef enum logic [1:0] {
        e_op_load  = 2'b00,
        e_op_store = 2'b01
    } op_e;

    // Return packet type encoding.
    typedef enum logic [1:0] {
        e_return_credit = 2'b00,
        e_return_int_wb = 2'b01
    } return_type_e;

    // Request layout: {addr, op, mask, payload, load_id, src_y, src_x}
    function automatic int req_pkt_width(
        input int x_cord_width,
        input int y_cord_width,
        input int data_width,
        input int addr_width,
        input int load_id_width
    );
        return addr_width + op_width_gp + data_width / 8 + data_width
             + load_id_width + y_cord_width + x_cord_width;
    endfunction

    // Return layout: {type, data, load_id, y_cord, x_cord}
    function automatic int ret_pkt_width(
        input int x_cord_width,
        input int y_cord_width,
        input int data_width,
        input int load_id_width
    );
        return 2 + data_width + load_id_width + y_cord_width + x_cord_width;
    endfunction

endpackage

// File: rtl/bsg_manycore_return_pkt_builder.sv
// Combinational assembly of a return packet from a captured header
// plus the SRAM read data.
// Ports:
//   pkt_type  - store credit or load data
//   mem_data  - SRAM read data (used only for load data)
//   drop_data - force the data field to zero (rejected load)
//   load_id   - load ID echoed back to the requester
//   dest_x/y  - requester coordinates
//   packet    - assembled return packet
module bsg_manycore_return_pkt_builder
    import bsg_manycore_mem_responder_pkg::*;
#(
    parameter int x_cord_width_p  = 4,
    parameter int y_cord_width_p  = 4,
    parameter int data_width_p    = 32,
    parameter int load_id_width_p = 5,
    localparam int ret_width_lp = ret_pkt_width(
        x_cord_width_p, y_cord_width_p, data_width_p, load_id_width_p)
) (
    input  return_type_e               pkt_type,
    input  logic [data_width_p-1:0]    mem_data,
    input  logic                       drop_data,
    input  logic [load_id_width_p-1:0] load_id,
    input  logic [x_cord_width_p-1:0]  dest_x,
    input  logic [y_cord_width_p-1:0]  dest_y,
    output logic [ret_width_lp-1:0]    packet
);

    typedef struct packed {
        logic [1:0]                 pkt_type;
        logic [data_width_p-1:0]    data;
        logic [load_id_width_p-1:0] load_id;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } ret_pkt_s;

    ret_pkt_s pkt;
    logic     keep_data;

    assign keep_data = (pkt_type == e_return_int_wb) && !drop_data;

    always_comb begin
        pkt          = '0;
        pkt.pkt_type = pkt_type;
        pkt.data     = keep_data ? mem_data : '0;
        pkt.load_id  = load_id;
        pkt.y_cord   = dest_y;
        pkt.x_cord   = dest_x;
    end

    assign packet = pkt;

endmodule

// File: rtl/bsg_manycore_mem_responder.sv
// Manycore endpoint memory responder: consumes request packets from the
// endpoint FIFO, drives a 1-cycle-latency SRAM and returns in-order
// store credits / load data with a single outstanding response.
// Ports:
//   clk_i, reset_i (sync, active-low)
//   in_packet_i / in_v_i / in_yumi_o         request side
//   mem_v_o / mem_w_o / mem_addr_o /
//   mem_data_o / mem_mask_o / mem_data_i     SRAM side
//   return_packet_o / return_v_o /
//   return_ready_i                           response side
//   error_o                                  out-of-range pulse
// Optional: define BSG_MANYCORE_MEM_RESPONDER_ADDR_CHECK_EN to reject
// addresses beyond the SRAM (consumed, no SRAM access, load data 0).
module bsg_manycore_mem_responder
    import bsg_manycore_mem_responder_pkg::*;
#(
    parameter int x_cord_width_p   = 4,
    parameter int y_cord_width_p   = 4,
    parameter int data_width_p     = 32,
    parameter int addr_width_p     = 32,
    parameter int load_id_width_p  = 5,
    parameter int mem_addr_width_p = 10,
    localparam int mask_width_lp   = data_width_p / 8,
    localparam int in_width_lp     = req_pkt_width(
        x_cord_width_p, y_cord_width_p, data_width_p,
        addr_width_p, load_id_width_p),
    localparam int ret_width_lp    = ret_pkt_width(
        x_cord_width_p, y_cord_width_p, data_width_p, load_id_width_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [in_width_lp-1:0]      in_packet_i,
    input  logic                        in_v_i,
    output logic                        in_yumi_o,
    output logic                        mem_v_o,
    output logic                        mem_w_o,
    output logic [mem_addr_width_p-1:0] mem_addr_o,
    output logic [data_width_p-1:0]     mem_data_o,
    output logic [mask_width_lp-1:0]    mem_mask_o,
    input  logic [data_width_p-1:0]     mem_data_i,
    output logic [ret_width_lp-1:0]     return_packet_o,
    output logic                        return_v_o,
    input  logic                        return_ready_i,
    output logic                        error_o
);

    typedef struct packed {
        logic [addr_width_p-1:0]    addr;
        logic [op_width_gp-1:0]     op;
        logic [mask_width_lp-1:0]   mask;
        logic [data_width_p-1:0]    payload;
        logic [load_id_width_p-1:0] load_id;
        logic [y_cord_width_p-1:0]  src_y;
        logic [x_cord_width_p-1:0]  src_x;
    } req_pkt_s;

    // Return header captured at acceptance; oor marks a rejected address.
    typedef struct packed {
        return_type_e               pkt_type;
        logic [load_id_width_p-1:0] load_id;
        logic [x_cord_width_p-1:0]  src_x;
        logic [y_cord_width_p-1:0]  src_y;
        logic                       oor;
    } hdr_s;

    req_pkt_s req;
    hdr_s     hdr_n, hdr_q;
    state_e   state_q, state_n;

    logic is_store;
    logic oor;
    logic accept;
    logic resp_v;
    logic latch_hold;

    logic [ret_width_lp-1:0] live_pkt;
    logic [ret_width_lp-1:0] hold_q;

    assign req      = in_packet_i;
    assign is_store = (req.op == e_op_store);

`ifdef BSG_MANYCORE_MEM_RESPONDER_ADDR_CHECK_EN
    assign oor     = |req.addr[addr_width_p-1:mem_addr_width_p];
    assign error_o = accept & oor;
`else
    logic unused_upper_addr;
    assign unused_upper_addr = |req.addr[addr_width_p-1:mem_addr_width_p];
    assign oor     = 1'b0;
    assign error_o = 1'b0;
`endif

    always_comb begin
        hdr_n          = '0;
        hdr_n.pkt_type = is_store ? e_return_credit : e_return_int_wb;
        hdr_n.load_id  = req.load_id;
        hdr_n.src_x    = req.src_x;
        hdr_n.src_y    = req.src_y;
        hdr_n.oor      = oor;
    end

    // Next request is only taken when the current response retires in
    // the same cycle, so at most one response is ever outstanding and a
    // stalled response never loses its SRAM read data.
    always_comb begin
        state_n    = state_q;
        accept     = 1'b0;
        resp_v     = 1'b0;
        latch_hold = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_v_i) begin
                    accept  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                resp_v = 1'b1;
                if (return_ready_i) begin
                    if (in_v_i) begin
                        accept  = 1'b1;
                        state_n = RESP;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    latch_hold = 1'b1;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                resp_v = 1'b1;
                if (return_ready_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // No handshake of either side may complete while in reset.
        if (!reset_i) begin
            accept     = 1'b0;
            resp_v     = 1'b0;
            latch_hold = 1'b0;
            state_n    = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_n;
            if (accept) begin
                hdr_q <= hdr_n;
            end
            if (latch_hold) begin
                hold_q <= live_pkt;
            end
        end
    end

    bsg_manycore_return_pkt_builder #(
        .x_cord_width_p  (x_cord_width_p),
        .y_cord_width_p  (y_cord_width_p),
        .data_width_p    (data_width_p),
        .load_id_width_p (load_id_width_p)
    ) builder (
        .pkt_type  (hdr_q.pkt_type),
        .mem_data  (mem_data_i),
        .drop_data (hdr_q.oor),
        .load_id   (hdr_q.load_id),
        .dest_x    (hdr_q.src_x),
        .dest_y    (hdr_q.src_y),
        .packet    (live_pkt)
    );

    assign in_yumi_o  = accept;
    assign mem_v_o    = accept & ~oor;
    assign mem_w_o    = is_store;
    assign mem_addr_o = req.addr[mem_addr_width_p-1:0];
    assign mem_data_o = req.payload;
    assign mem_mask_o = req.mask;

    assign return_v_o      = resp_v;
    assign return_packet_o = (state_q == HOLD) ? hold_q : live_pkt;

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Scoreboard bench for bsg_manycore_mem_responder: directed requests,
// behavioural 1-cycle SRAM, queue of expected return packets.
module tb_bsg_manycore_mem_responder;

    localparam int XW = 4;
    localparam int YW = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 5;
    localparam int MW = 10;
    localparam int IW = AW + 2 + DW / 8 + DW + LW + YW + XW;
    localparam int RW = 2 + DW + LW + YW + XW;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [1:0]      op;
        logic [DW/8-1:0] mask;
        logic [DW-1:0]   payload;
        logic [LW-1:0]   load_id;
        logic [YW-1:0]   src_y;
        logic [XW-1:0]   src_x;
    } req_t;

    typedef struct packed {
        logic [1:0]    typ;
        logic [DW-1:0] data;
        logic [LW-1:0] load_id;
        logic [YW-1:0] y;
        logic [XW-1:0] x;
    } ret_t;

    logic            clk;
    logic            reset_i;
    logic [IW-1:0]   in_packet;
    logic            in_v;
    logic            in_yumi_o;
    logic            mem_v_o;
    logic            mem_w_o;
    logic [MW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_data_o;
    logic [DW/8-1:0] mem_mask_o;
    logic [DW-1:0]   mem_rdata;
    logic [RW-1:0]   return_packet_o;
    logic            return_v_o;
    logic            return_ready;
    logic            error_o;

    int errors = 0;
    int checks = 0;
    ret_t q[$];

    bsg_manycore_mem_responder #(
        .x_cord_width_p   (XW),
        .y_cord_width_p   (YW),
        .data_width_p     (DW),
        .addr_width_p     (AW),
        .load_id_width_p  (LW),
        .mem_addr_width_p (MW)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .in_packet_i     (in_packet),
        .in_v_i          (in_v),
        .in_yumi_o       (in_yumi_o),
        .mem_v_o         (mem_v_o),
        .mem_w_o         (mem_w_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .mem_mask_o      (mem_mask_o),
        .mem_data_i      (mem_rdata),
        .return_packet_o (return_packet_o),
        .return_v_o      (return_v_o),
        .return_ready_i  (return_ready),
        .error_o         (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous SRAM with byte write mask.
    logic [DW-1:0] mem [1 << MW];
    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) begin
                for (int b = 0; b < DW / 8; b++)
                    if (mem_mask_o[b])
                        mem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr_o];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic req_t mk(input logic st, input logic [AW-1:0] addr,
                                input logic [DW-1:0] pay,
                                input logic [3:0] mask, input logic [3:0] sx,
                                input logic [3:0] sy, input logic [4:0] id);
        req_t r;
        r.addr    = addr;
        r.op      = st ? 2'b01 : 2'b00;
        r.mask    = mask;
        r.payload = pay;
        r.load_id = id;
        r.src_y   = sy;
        r.src_x   = sx;
        return r;
    endfunction

    // Presents a request, waits for in_yumi_o, checks the SRAM strobe
    // and pushes the expected return packet.
    task automatic send(input logic st, input logic [AW-1:0] addr,
                        input logic [DW-1:0] pay, input logic [3:0] mask,
                        input logic [3:0] sx, input logic [3:0] sy,
                        input logic [4:0] id, input logic [DW-1:0] exp_data,
                        input logic exp_oor);
        ret_t e;
        int   n;
        bit   ok;
        logic [MW-1:0] a;
        in_packet = mk(st, addr, pay, mask, sx, sy, id);
        in_v      = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_yumi_o) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            chk("accept_timeout", 64'(n), 64'(0));
        end else begin
            a = addr[MW-1:0];
            chk("mem_v", 64'(mem_v_o), 64'(!exp_oor));
            chk("mem_w", 64'(mem_w_o), 64'(st));
            chk("error", 64'(error_o), 64'(exp_oor));
            if (!exp_oor) chk("mem_addr", 64'(mem_addr_o), 64'(a));
            if (st) begin
                chk("mem_data", 64'(mem_data_o), 64'(pay));
                chk("mem_mask", 64'(mem_mask_o), 64'(mask));
            end
            e.typ     = st ? 2'b00 : 2'b01;
            e.data    = st ? '0 : exp_data;
            e.load_id = id;
            e.y       = sy;
            e.x       = sx;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_v = 1'b0;
    endtask

    // Monitor: compares each presented response against the queue head;
    // a stalled response must match the head and block new requests.
    always @(negedge clk) begin
        if (reset_i && return_v_o) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 64'(return_packet_o), 64'(0));
            end else begin
                chk("resp_pkt", 64'(return_packet_o), 64'(q[0]));
                if (return_ready) void'(q.pop_front());
                else chk("yumi_in_stall", 64'(in_yumi_o), 64'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        time t0;
        int  n;
        reset_i      = 1'b0;
        in_v         = 1'b1;
        in_packet    = '0;
        return_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_yumi", 64'(in_yumi_o), 64'(0));
        chk("rst_mem_v", 64'(mem_v_o), 64'(0));
        chk("rst_ret_v", 64'(return_v_o), 64'(0));
        chk("rst_error", 64'(error_o), 64'(0));
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        in_v    = 1'b0;
        tick();

        // store then readback
        send(1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd2, 4'd3, 5'd1, 32'h0, 0);
        send(0, 32'h10, 32'h0, 4'h0, 4'd2, 4'd3, 5'd2, 32'hDEADBEEF, 0);

        // preload
        for (int i = 0; i < 4; i++)
            send(1, 32'(i), 32'hA0 + 32'(i), 4'hF, 4'd1, 4'd1, 5'(i), 32'h0, 0);
        send(1, 32'h5, 32'h55, 4'hF, 4'd1, 4'd1, 5'd6, 32'h0, 0);
        tick();

        // back-to-back loads
        t0 = $time;
        for (int i = 0; i < 4; i++)
            send(0, 32'(i), 32'h0, 4'h0, 4'd4, 4'd5, 5'(i), 32'hA0 + 32'(i), 0);
        chk("b2b_cycles", 64'(($time - t0) / 10), 64'(4));
        tick();

        // stalled response, next request waiting upstream
        return_ready = 1'b0;
        send(0, 32'h5, 32'h0, 4'h0, 4'd7, 4'd6, 5'd9, 32'h55, 0);
        in_packet = mk(1, 32'h20, 32'h11223344, 4'hF, 4'd1, 4'd2, 5'd10);
        in_v      = 1'b1;
        repeat (3) tick();
        return_ready = 1'b1;
        n = q.size();
        send(1, 32'h20, 32'h11223344, 4'hF, 4'd1, 4'd2, 5'd10, 32'h0, 0);
        chk("hold_retired", 64'(n), 64'(1));

        // byte-masked store
        send(1, 32'h20, 32'h0000AB00, 4'b0010, 4'd1, 4'd2, 5'd11, 32'h0, 0);
        send(0, 32'h20, 32'h0, 4'h0, 4'd3, 4'd4, 5'd12, 32'h1122AB44, 0);
        tick();

        // reset while holding; retained request served afterwards
        return_ready = 1'b0;
        send(0, 32'h1, 32'h0, 4'h0, 4'd5, 4'd5, 5'd4, 32'hA1, 0);
        in_packet = mk(0, 32'h2, 32'h0, 4'h0, 4'd6, 4'd6, 5'd5);
        in_v      = 1'b1;
        tick();
        reset_i = 1'b0;
        q.delete();
        @(negedge clk);
        chk("rstmid_ret_v", 64'(return_v_o), 64'(0));
        chk("rstmid_yumi", 64'(in_yumi_o), 64'(0));
        tick();
        @(negedge clk);
        chk("rstmid_ret_v2", 64'(return_v_o), 64'(0));
        tick();
        reset_i      = 1'b1;
        return_ready = 1'b1;
        send(0, 32'h2, 32'h0, 4'h0, 4'd6, 4'd6, 5'd5, 32'hA2, 0);

`ifdef BSG_MANYCORE_MEM_RESPONDER_ADDR_CHECK_EN
        send(0, 32'h400, 32'h0, 4'h0, 4'd2, 4'd2, 5'd3, 32'h0, 1);
        @(negedge clk);
        chk("error_pulse_end", 64'(error_o), 64'(0));
        send(1, 32'h401, 32'h5, 4'hF, 4'd2, 4'd2, 5'd7, 32'h0, 1);
        send(0, 32'h1, 32'h0, 4'h0, 4'd2, 4'd2, 5'd8, 32'hA1, 0);
`endif

        n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
